// File: rtl/if_id_skid_stage.sv
// -----------------------------------------------------------------------------
// if_id_skid_stage
//
// IF/ID pipeline register with a valid/ready handshake and a DEPTH-entry skid
// FIFO. Fetch responses arrive one cycle after the request because the
// instruction memory has a read latency of one cycle. Any response that lands
// while decode is stalled is parked in the FIFO instead of being dropped. The
// output register always drains the FIFO before it takes a new input, so
// program order is kept. Flush empties the stage and puts a NOP bubble on the
// output.
//
// Ports
//   sys_clk      in   clock, rising edge
//   sys_arstn    in   asynchronous active-low reset
//   flag_flush   in   drop every held and in-flight instruction
//   flag_hold    in   stall request vector, one bit per hold source
//   in_valid     in   fetch response valid
//   in_ready     out  a fetch response can be accepted this cycle
//   inst_data_i  in   fetched instruction
//   inst_addr_i  in   address of the fetched instruction
//   out_valid    out  inst_data_o/inst_addr_o hold a real instruction
//   out_ready    in   decode consumes the output this cycle
//   inst_data_o  out  instruction to decode
//   inst_addr_o  out  address of inst_data_o
//   fill_level   out  current skid FIFO occupancy
//
// DEPTH may be any value from 1 to 8. It does not have to be a power of two.
// -----------------------------------------------------------------------------
module if_id_skid_stage #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                HOLD_W   = 3,
  parameter int                DEPTH    = 2,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                         sys_clk,
  input  logic                         sys_arstn,
  input  logic                         flag_flush,
  input  logic [HOLD_W-1:0]            flag_hold,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            inst_data_i,
  input  logic [ADDR_W-1:0]            inst_addr_i,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            inst_data_o,
  output logic [ADDR_W-1:0]            inst_addr_o,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [ADDR_W-1:0] r_mem_addr [DEPTH];

  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_addr;

  logic              w_hold;
  logic              w_stall;
  logic              w_in_ready;
  logic              w_push;
  logic              w_empty;
  logic              w_fifo_wr;
  logic              w_fifo_rd;
  logic [PTR_W-1:0]  w_rd_ptr_nxt;
  logic [PTR_W-1:0]  w_wr_ptr_nxt;

  assign w_hold  = |flag_hold;
  assign w_stall = w_hold | (r_out_valid & ~out_ready);
  assign w_empty = (r_count == '0);

  // in_ready depends only on the registered count. This keeps hold, out_ready
  // and flush out of the timing path back to fetch. As a result, a full FIFO
  // that pops this cycle still reports not-ready until the next cycle.
  assign w_in_ready = (r_count != FULL_CNT);
  assign w_push     = in_valid & w_in_ready;

  // The FIFO takes a push whenever the output cannot bypass it. That happens
  // when the stage is stalled, or when older entries are still queued.
  assign w_fifo_wr = ~flag_flush & w_push & (w_stall | ~w_empty);
  assign w_fifo_rd = ~flag_flush & ~w_stall & ~w_empty;

  // Pointers wrap explicitly, so DEPTH need not be a power of two.
  assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
  assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;

  // Storage has no reset. Only entries below r_count are ever read.
  always_ff @(posedge sys_clk) begin
    if (w_fifo_wr) begin
      r_mem_data[r_wr_ptr] <= inst_data_i;
      r_mem_addr[r_wr_ptr] <= inst_addr_i;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else if (flag_flush) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_fifo_wr) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_fifo_rd) r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_fifo_wr, w_fifo_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register. The order of the branches sets the priority:
  // flush, then stall, then FIFO head, then bypass, then bubble.
  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
    end else if (flag_flush) begin
      r_out_valid <= 1'b0;
      r_out_data  <= NOP_INST;
      r_out_addr  <= '0;
    end else if (w_stall) begin
      r_out_valid <= r_out_valid;
      r_out_data  <= r_out_data;
      r_out_addr  <= r_out_addr;
    end else if (!w_empty) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_mem_data[r_rd_ptr];
      r_out_addr  <= r_mem_addr[r_rd_ptr];
    end else if (w_push) begin
      r_out_valid <= 1'b1;
      r_out_data  <= inst_data_i;
      r_out_addr  <= inst_addr_i;
    end else begin
      r_out_valid <= 1'b0;
      r_out_data  <= NOP_INST;
      r_out_addr  <= '0;
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign inst_data_o = r_out_data;
  assign inst_addr_o = r_out_addr;
  assign fill_level  = r_count;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_skid_stage
//
// Directed bench for if_id_skid_stage. Instance u_dut_a (DEPTH=2) runs the
// hold, out_ready, flush and flush+hold scenarios. Instance u_dut_b (DEPTH=3)
// runs a back-to-back stream of ten instructions under random stalls. Its
// consumed words must come out in sequence 0x1000, 0x1001, ...
// -----------------------------------------------------------------------------
module tb_if_id_skid_stage;

  logic sys_clk = 1'b0;
  logic sys_arstn;
  always #5 sys_clk = ~sys_clk;

  // DEPTH=2 instance
  logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [2:0]  hold_a;
  logic [31:0] data_i_a, addr_i_a, data_o_a, addr_o_a;
  logic [1:0]  fill_a;

  // DEPTH=3 instance
  logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [2:0]  hold_b;
  logic [31:0] data_i_b, addr_i_b, data_o_b, addr_o_b;
  logic [1:0]  fill_b;

  int checks = 0;
  int errors = 0;

  if_id_skid_stage #(.DEPTH(2)) u_dut_a (
    .sys_clk(sys_clk), .sys_arstn(sys_arstn), .flag_flush(flush_a),
    .flag_hold(hold_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .inst_data_i(data_i_a), .inst_addr_i(addr_i_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .inst_data_o(data_o_a), .inst_addr_o(addr_o_a),
    .fill_level(fill_a)
  );

  if_id_skid_stage #(.DEPTH(3)) u_dut_b (
    .sys_clk(sys_clk), .sys_arstn(sys_arstn), .flag_flush(flush_b),
    .flag_hold(hold_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .inst_data_i(data_i_b), .inst_addr_i(addr_i_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .inst_data_o(data_o_b), .inst_addr_o(addr_o_b),
    .fill_level(fill_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic [31:0] d, input logic [31:0] a);
    in_valid_a = v;
    data_i_a   = d;
    addr_i_a   = a;
  endtask

  task automatic chk_out_a(input string tag, input logic v, input logic [31:0] d,
                           input logic [31:0] a, input logic [1:0] f);
    chk({tag, "_valid"}, 64'(out_valid_a), 64'(v));
    chk({tag, "_data"},  64'(data_o_a),    64'(d));
    chk({tag, "_addr"},  64'(addr_o_a),    64'(a));
    chk({tag, "_fill"},  64'(fill_a),      64'(f));
  endtask

  initial begin
    int sent, rcv, cyc, max_fill;

    sys_arstn   = 1'b0;
    flush_a     = 1'b0; hold_a = 3'b000; out_ready_a = 1'b1;
    drv_a(1'b0, 32'h0, 32'h0);
    flush_b     = 1'b0; hold_b = 3'b000; out_ready_b = 1'b1;
    in_valid_b  = 1'b0; data_i_b = 32'h0; addr_i_b = 32'h0;

    #12;
    chk_out_a("reset", 1'b0, 32'h0, 32'h0, 2'd0);
    chk("reset_in_ready", 64'(in_ready_a), 64'd1);
    chk("reset_b_valid", 64'(out_valid_b), 64'd0);
    @(negedge sys_clk);
    sys_arstn = 1'b1;

    // Empty-FIFO bypass: one cycle of latency.
    drv_a(1'b1, 32'h0050_0093, 32'h0);
    tick();
    chk_out_a("bypass", 1'b1, 32'h0050_0093, 32'h0, 2'd0);

    // Hold for 3 cycles while A, B, C are offered. C must wait.
    hold_a = 3'b001;
    drv_a(1'b1, 32'hA, 32'h4);
    tick();
    chk_out_a("hold1", 1'b1, 32'h0050_0093, 32'h0, 2'd1);
    drv_a(1'b1, 32'hB, 32'h8);
    tick();
    chk_out_a("hold2", 1'b1, 32'h0050_0093, 32'h0, 2'd2);
    chk("hold2_in_ready", 64'(in_ready_a), 64'd0);
    drv_a(1'b1, 32'hC, 32'hC);
    tick();
    chk_out_a("hold3", 1'b1, 32'h0050_0093, 32'h0, 2'd2);
    hold_a = 3'b000;
    tick();
    chk_out_a("rel_A", 1'b1, 32'hA, 32'h4, 2'd1);
    chk("rel_A_in_ready", 64'(in_ready_a), 64'd1);
    tick();
    chk_out_a("rel_B", 1'b1, 32'hB, 32'h8, 2'd1);
    drv_a(1'b0, 32'h0, 32'h0);
    tick();
    chk_out_a("rel_C", 1'b1, 32'hC, 32'hC, 2'd0);
    tick();
    chk_out_a("bubble", 1'b0, 32'h13, 32'h0, 2'd0);

    // Backpressure from out_ready.
    drv_a(1'b1, 32'hD, 32'h10);
    tick();
    chk_out_a("bp_D", 1'b1, 32'hD, 32'h10, 2'd0);
    out_ready_a = 1'b0;
    drv_a(1'b1, 32'hE, 32'h14);
    tick();
    chk_out_a("bp_stall", 1'b1, 32'hD, 32'h10, 2'd1);
    out_ready_a = 1'b1;
    drv_a(1'b1, 32'hF, 32'h18);
    tick();
    chk_out_a("bp_E", 1'b1, 32'hE, 32'h14, 2'd1);
    drv_a(1'b0, 32'h0, 32'h0);
    tick();
    chk_out_a("bp_F", 1'b1, 32'hF, 32'h18, 2'd0);

    // Flush with a full FIFO and a live input.
    out_ready_a = 1'b0;
    drv_a(1'b1, 32'h1C, 32'h1C);
    tick();
    drv_a(1'b1, 32'h20, 32'h20);
    tick();
    chk_out_a("pre_flush", 1'b1, 32'hF, 32'h18, 2'd2);
    flush_a = 1'b1;
    drv_a(1'b1, 32'h24, 32'h24);
    tick();
    chk_out_a("flush", 1'b0, 32'h13, 32'h0, 2'd0);
    chk("flush_in_ready", 64'(in_ready_a), 64'd1);
    flush_a = 1'b0; out_ready_a = 1'b1;
    drv_a(1'b0, 32'h0, 32'h0);
    tick();
    chk_out_a("post_flush", 1'b0, 32'h13, 32'h0, 2'd0);

    // Flush together with hold. J is already queued and K is pushed in the
    // flush cycle. Both must vanish, and L is the first thing released.
    hold_a = 3'b010;
    drv_a(1'b1, 32'h28, 32'h28);
    tick();
    chk("fh_queued", 64'(fill_a), 64'd1);
    flush_a = 1'b1;
    drv_a(1'b1, 32'h2C, 32'h2C);
    tick();
    chk_out_a("fh_flush", 1'b0, 32'h13, 32'h0, 2'd0);
    flush_a = 1'b0;
    drv_a(1'b1, 32'h30, 32'h30);
    tick();
    chk_out_a("fh_hold1", 1'b0, 32'h13, 32'h0, 2'd1);
    drv_a(1'b0, 32'h0, 32'h0);
    tick();
    chk_out_a("fh_hold2", 1'b0, 32'h13, 32'h0, 2'd1);
    hold_a = 3'b000;
    tick();
    chk_out_a("fh_release", 1'b1, 32'h30, 32'h30, 2'd0);

    // DEPTH=3: ten back-to-back instructions with random hold and out_ready.
    // The first four cycles are held, so the FIFO fills and the pointers wrap.
    sent = 0; rcv = 0; cyc = 0; max_fill = 0;
    while (rcv < 10 && cyc < 300) begin
      in_valid_b  = (sent < 10);
      data_i_b    = 32'(32'h1000 + sent);
      addr_i_b    = 32'(sent * 4);
      hold_b      = (cyc < 4) ? 3'b100 : (($urandom_range(0, 3) == 0) ? 3'b010 : 3'b000);
      out_ready_b = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid_b && in_ready_b) sent++;
      if (out_valid_b && out_ready_b && hold_b == 3'b000) begin
        chk("seq_data", 64'(data_o_b), 64'(32'h1000 + rcv));
        chk("seq_addr", 64'(addr_o_b), 64'(rcv * 4));
        rcv++;
      end
      tick();
      if (int'(fill_b) > max_fill) max_fill = int'(fill_b);
      cyc++;
    end
    in_valid_b = 1'b0;
    chk("seq_count", 64'(rcv), 64'd10);
    chk("seq_max_fill", 64'(max_fill), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_skid_stage.md
# if_id_skid_stage

Parametrised IF/ID pipeline stage with a valid/ready handshake and a DEPTH-entry skid FIFO. It sits between the fetch unit, whose instruction memory has a one-cycle read latency, and decode. Fetch responses that arrive while decode is held are captured instead of lost. All outputs are registered, and flush replaces the stage contents with NOP bubbles.

## Interface
- DATA_W, 32: instruction word width
- ADDR_W, 32: instruction address width
- HOLD_W, 3: width of hold request vector (one bit per hold source)
- DEPTH, 2: skid FIFO entries, legal range 1..8
- NOP_INST, 32'h0000_0013: bubble instruction (addi x0,x0,0), DATA_W bits

Ports:
- sys_clk  in  1  clock; all state updates on rising edge
- sys_arstn  in  1  asynchronous, active-low reset
- flag_flush  in  1  discard all held and in-flight instructions
- flag_hold  in  HOLD_W  stall request; any set bit holds the output register
- in_valid  in  1  fetch response valid
- in_ready  out  1  stage can accept a fetch response this cycle
- inst_data_i  in  DATA_W  fetched instruction
- inst_addr_i  in  ADDR_W  fetched instruction address
- out_valid  out  1  inst_data_o/inst_addr_o hold a real instruction
- out_ready  in  1  decode consumes the output this cycle
- inst_data_o  out  DATA_W  instruction to decode
- inst_addr_o  out  ADDR_W  address of inst_data_o
- fill_level  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- Terms:
  - hold = |flag_hold
  - stall = hold | (out_valid & ~out_ready)
  - push = in_valid & in_ready
  - advance = ~stall
- in_ready = (fill_level != DEPTH). It depends only on registered count. There is no combinational path from flag_hold, out_ready or flag_flush.
- Output register update, in priority order:
  - flag_flush=1: FIFO emptied (fill_level 0), out_valid<=0, inst_data_o<=NOP_INST, inst_addr_o<=0. A push in the same cycle is discarded.
  - stall: output register unchanged. Push writes the FIFO tail.
  - advance with FIFO non-empty: output loads the FIFO head, out_valid<=1, pop. A simultaneous push writes the tail, so count is unchanged.
  - advance with FIFO empty and push: bypass; output loads inst_data_i/inst_addr_i, out_valid<=1. FIFO untouched.
  - advance with FIFO empty and no push: bubble; out_valid<=0, inst_data_o<=NOP_INST, inst_addr_o<=0.
- Ordering: strict program order. FIFO entries always precede the current input.
- Full FIFO with advance: pop occurs, but in_ready stays 0 that cycle because it comes from count. The next cycle in_ready=1.
- fill_level never exceeds DEPTH. A push while full cannot occur, because in_ready=0.
- FIFO is a circular buffer:
  - read/write pointers wrap DEPTH-1 -> 0
  - DEPTH need not be a power of two
  - pointers are reset to 0 on flush

## Timing
- Reset (asynchronous, immediate): out_valid=0, inst_data_o=0, inst_addr_o=0, fill_level=0, in_ready=1, pointers 0.
- Latency with the FIFO empty and no stall: inst_data_i sampled at edge N appears on inst_data_o after edge N (1 cycle).
- Hold asserted in cycle N: output frozen from edge N onward. The fetch response arriving in cycle N, and any later ones, go to the FIFO up to DEPTH.
- Hold released in cycle M: at edge M the output takes the FIFO head. A stalled run drains one entry per cycle while no new stall occurs.
- Flush is a 1-cycle pulse. At the following edge:
  - output shows NOP_INST with out_valid=0
  - in_ready=1
- Flush together with hold: flush wins. The stage still holds NOP while hold persists.
- Reset deasserted mid-stream: the first accepted input after reset follows the empty-FIFO bypass rule.

## Test plan
- Reset, then inst 0x00500093@0x0 with in_valid=1, no hold -> next cycle inst_data_o=0x00500093, inst_addr_o=0x0, out_valid=1; fill_level stays 0.
- Hold=3'b001 for 3 cycles while feeding A@0x4, B@0x8, C@0xC (DEPTH=2):
  - output frozen on the prior instruction
  - fill_level 1 then 2
  - in_ready=0 after two pushes, so C is not accepted
  - after release, outputs A then B on consecutive cycles; C is accepted once in_ready=1
- out_ready=0 with out_valid=1 and FIFO empty, 1 push -> output unchanged, fill_level=1. Raise out_ready -> FIFO entry shown next cycle, and a same-cycle input goes to the tail (fill_level stays 1).
- Flush with fill_level=2 and in_valid=1 -> next cycle:
  - inst_data_o=0x00000013, inst_addr_o=0, out_valid=0
  - fill_level=0, in_ready=1
  - the flushed-cycle input never appears
- Flush and hold asserted together -> NOP with out_valid=0 held for the duration of the hold. The first instruction after release is the first post-flush push.
- DEPTH=3, 10 back-to-back pushes with random hold/out_ready patterns -> output sequence equals input sequence exactly, with pointer wrap exercised and fill_level never above 3.
